// File: rtl/proj_hv_pkg.sv
// Shared constants, pair type and FSM state encoding for the projection binder.
package proj_hv_pkg;
  localparam int PROJ_DHV_SIZE   = 4000;
  localparam int PROJ_IN_WIDTH   = 16;
  localparam int PROJ_ADDR_WIDTH = 8;
  localparam int NUM_WORDS       = PROJ_DHV_SIZE / PROJ_IN_WIDTH;
  localparam int NUM_PAIRS       = NUM_WORDS / 2;

  typedef logic [2*PROJ_IN_WIDTH-1:0] proj_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } proj_state_t;
endpackage

// File: rtl/proj_pair_fifo.sv
// Two-entry FIFO holding returned memory word pairs until a key pair arrives.
module proj_pair_fifo
  import proj_hv_pkg::*;
#(
  parameter int WIDTH = $bits(proj_pair_t)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             empty
);
  logic [WIDTH-1:0] slot0, slot1;
  logic             wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= din;
        else        slot0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign dout  = rd_ptr ? slot1 : slot0;
  assign empty = (count == 2'd0);
endmodule

// File: rtl/proj_hv_binder.sv
// Sweeps the projection memory two words per cycle and XOR-binds each pair with a key pair.
// Optional Hamming-weight accumulator is built when PROJ_HV_WEIGHT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start with the projection loaded
// FETCH | issuing pair reads, binding as keys arrive
// DRAIN | all reads issued, emptying FIFO and output register
// DONE  | one-cycle end-of-sweep pulse
module proj_hv_binder
  import proj_hv_pkg::*;
#(
  parameter int DHV_SIZE   = PROJ_DHV_SIZE,
  parameter int IN_WIDTH   = PROJ_IN_WIDTH,
  parameter int ADDR_WIDTH = PROJ_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  proj_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [ADDR_WIDTH-1:0] mem_addr1,
  input  logic [IN_WIDTH-1:0]   mem_out0,
  input  logic [IN_WIDTH-1:0]   mem_out1,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [2*IN_WIDTH-1:0] key_data,
  output logic                  bound_valid,
  input  logic                  bound_ready,
  output logic [2*IN_WIDTH-1:0] bound_data,
  output logic                  bound_last
`ifdef PROJ_HV_WEIGHT_EN
  ,
  output logic [$clog2(DHV_SIZE+1)-1:0] weight
`endif
);
  localparam int PAIRS = DHV_SIZE / IN_WIDTH / 2;
  localparam int PW    = $clog2(PAIRS + 1);

  proj_state_t           state;
  logic [PW-1:0]         next_pair;
  logic [PW-1:0]         out_idx;
  logic                  data_pend;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic [2*IN_WIDTH-1:0] fifo_head;
  logic                  load, push, can_issue, start_acc;

  // Memory holds its output until the next read, so an unpushed pair waits there.
  assign load      = !fifo_empty && key_valid && (!bound_valid || bound_ready);
  assign push      = data_pend && ((fifo_count != 2'd2) || load);
  assign can_issue = ({1'b0, fifo_count} + {2'b0, mem_re}) < (3'd2 + {2'b0, load});
  assign start_acc = (state == ST_IDLE) && start && proj_ready;
  assign key_ready = load;

  proj_pair_fifo #(.WIDTH(2*IN_WIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (load),
    .din   ({mem_out1, mem_out0}),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr0 <= '0;
      mem_addr1 <= '0;
      next_pair <= '0;
      data_pend <= 1'b0;
    end else begin
      mem_re    <= 1'b0;
      data_pend <= mem_re || (data_pend && !push);
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state     <= (PAIRS == 1) ? ST_DRAIN : ST_FETCH;
            busy      <= 1'b1;
            mem_re    <= 1'b1;
            mem_addr0 <= ADDR_WIDTH'(0);
            mem_addr1 <= ADDR_WIDTH'(1);
            next_pair <= PW'(1);
          end
        end
        ST_FETCH: begin
          if (can_issue) begin
            mem_re    <= 1'b1;
            mem_addr0 <= ADDR_WIDTH'({next_pair, 1'b0});
            mem_addr1 <= ADDR_WIDTH'({next_pair, 1'b1});
            next_pair <= next_pair + PW'(1);
            if (next_pair == PW'(PAIRS - 1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bound_valid && bound_ready && bound_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bound_valid <= 1'b0;
      bound_data  <= '0;
      bound_last  <= 1'b0;
      out_idx     <= '0;
    end else begin
      if (start_acc) out_idx <= '0;
      if (load) begin
        bound_valid <= 1'b1;
        bound_data  <= fifo_head ^ key_data;
        bound_last  <= (out_idx == PW'(PAIRS - 1));
        out_idx     <= out_idx + PW'(1);
      end else if (bound_ready) begin
        bound_valid <= 1'b0;
        bound_last  <= 1'b0;
      end
    end
  end

`ifdef PROJ_HV_WEIGHT_EN
  localparam int WW = $clog2(DHV_SIZE + 1);
  always_ff @(posedge clk) begin
    if (reset || start_acc) weight <= '0;
    else if (bound_valid && bound_ready) weight <= weight + WW'($countones(bound_data));
  end
`endif
endmodule

// File: tb/tb_proj_hv_binder.sv
// Randomized self-checking bench for proj_hv_binder with a pair-level reference model.
module tb_proj_hv_binder;
  import proj_hv_pkg::*;

  localparam int NP = NUM_PAIRS;

  logic        clk = 1'b0;
  logic        reset, start, proj_ready;
  logic        busy, done, mem_re;
  logic [7:0]  mem_addr0, mem_addr1;
  logic [15:0] mem_out0, mem_out1;
  logic        key_valid, key_ready;
  logic [31:0] key_data;
  logic        bound_valid, bound_ready, bound_last;
  logic [31:0] bound_data;
`ifdef PROJ_HV_WEIGHT_EN
  logic [11:0] weight;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Memory word k holds the value k; output holds between reads.
  always @(posedge clk) begin
    if (mem_re) begin
      mem_out0 <= 16'(mem_addr0);
      mem_out1 <= 16'(mem_addr1);
    end
  end

  proj_hv_binder dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .proj_ready  (proj_ready),
    .busy        (busy),
    .done        (done),
    .mem_re      (mem_re),
    .mem_addr0   (mem_addr0),
    .mem_addr1   (mem_addr1),
    .mem_out0    (mem_out0),
    .mem_out1    (mem_out1),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_data    (key_data),
    .bound_valid (bound_valid),
    .bound_ready (bound_ready),
    .bound_data  (bound_data),
    .bound_last  (bound_last)
`ifdef PROJ_HV_WEIGHT_EN
    ,
    .weight      (weight)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] mem_pair(input int c);
    return {16'(2*c + 1), 16'(2*c)};
  endfunction

  // key_mode: 0 const FFFF, 1 random, 2 zero. br_mode: 0 high, 1 toggle, 2 random.
  task automatic run_sweep(input int key_mode, input int kv_mode, input int br_mode,
                           input int starve, input int start_again, input int abort_at,
                           input bit check_timing);
    logic [31:0] exp_q[$];
    logic [31:0] expv, prev_bd, kconst;
    logic        prev_bl, prev_stall;
    int consumed, xfers, n_re, re_starve, first_bv, done_cyc, last_xfer, wacc;
    bit fin;
    consumed = 0; xfers = 0; n_re = 0; re_starve = 0; first_bv = -1;
    done_cyc = -1; last_xfer = -1; wacc = 0; fin = 0; prev_stall = 0;
    prev_bd = '0; prev_bl = 0;
    kconst = (key_mode == 0) ? 32'hFFFF_FFFF : 32'h0;

    @(negedge clk);
    start = 1; proj_ready = 1; key_valid = 0; bound_ready = 1; key_data = kconst;
    @(negedge clk);
    start = 0;
    for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
      if (prev_stall) begin
        check("hold_data", bound_data, prev_bd);
        check("hold_last", bound_last, prev_bl);
      end
      if (mem_re) begin
        check("addr0", mem_addr0, 64'(2*n_re));
        check("addr1", mem_addr1, 64'(2*n_re + 1));
        n_re++;
        if (cyc <= starve) re_starve++;
      end
      if (bound_valid && first_bv < 0) first_bv = cyc;
      if (done) begin done_cyc = cyc; fin = 1; end

      start       = (cyc == start_again);
      if (br_mode == 2 && cyc > 3) proj_ready = 0;
      key_valid   = (cyc <= starve) ? 1'b0 : (kv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bound_ready = (br_mode == 0) ? 1'b1 : (br_mode == 1) ? 1'(cyc % 2 == 1)
                  : 1'($urandom_range(0, 3) != 0);
      key_data    = (key_mode == 1) ? $urandom : kconst;
      #1;
      if (cyc <= starve) check("key_ready_starved", key_ready, 0);
      if (key_ready) begin
        if (!key_valid) check("key_ready_no_valid", key_valid, 1);
        exp_q.push_back(mem_pair(consumed) ^ key_data);
        consumed++;
      end
      if (bound_valid && bound_ready) begin
        xfers++;
        last_xfer = cyc;
        if (exp_q.size() == 0) check("unexpected_xfer", 1, 0);
        else begin
          expv = exp_q.pop_front();
          check("bound_data", bound_data, expv);
        end
        check("bound_last", bound_last, 64'(xfers == NP));
        wacc += $countones(bound_data);
        if (xfers == abort_at) return;
      end
      prev_stall = bound_valid && !bound_ready;
      prev_bd    = bound_data;
      prev_bl    = bound_last;
      if (!fin) @(negedge clk);
    end

    check("sweep_done_seen", 64'(done_cyc > 0), 1);
    check("busy_in_done", busy, 1);
    check("xfer_count", xfers, NP);
    check("read_count", n_re, NP);
    check("done_after_last", done_cyc, last_xfer + 1);
    check("final_addr0", mem_addr0, 2*NP - 2);
    check("final_addr1", mem_addr1, 2*NP - 1);
    if (check_timing) begin
      check("first_bound_cycle", first_bv, 4);
      check("done_cycle", done_cyc, NP + 4);
    end
    if (starve > 0) check("reads_while_starved", re_starve, 3);
`ifdef PROJ_HV_WEIGHT_EN
    check("weight", weight, wacc);
    if (key_mode == 2) check("weight_key0", weight, 983);
`endif
    @(negedge clk);
    check("busy_after", busy, 0);
    check("done_pulse", done, 0);
  endtask

  initial begin
    bit saw_busy, saw_re;
    reset = 1; start = 0; proj_ready = 0; key_valid = 1; bound_ready = 1; key_data = '0;
    mem_out0 = '0; mem_out1 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_addrs", {mem_addr1, mem_addr0}, 0);
    check("rst_bound", {bound_valid, bound_last, bound_data}, 0);
    check("rst_key_ready", key_ready, 0);
    reset = 0;

    // start without a loaded projection
    @(negedge clk);
    start = 1; proj_ready = 0;
    saw_busy = 0; saw_re = 0;
    repeat (6) begin
      @(negedge clk);
      saw_busy |= busy;
      saw_re   |= mem_re;
    end
    check("noproj_busy", saw_busy, 0);
    check("noproj_mem_re", saw_re, 0);
    start = 0;

    run_sweep(0, 0, 0, 0, 0, 0, 1);
    run_sweep(0, 0, 1, 0, 20, 0, 0);
    run_sweep(1, 1, 2, 0, 0, 0, 0);
    run_sweep(0, 0, 0, 10, 0, 0, 0);

    // reset after pair 50 accepted, then restart from pair 0
    run_sweep(0, 0, 0, 0, 0, 50, 0);
    @(negedge clk);
    reset = 1; key_valid = 1; bound_ready = 1;
    @(negedge clk);
    check("mid_rst_ctrl", {busy, done, mem_re, key_ready}, 0);
    check("mid_rst_addrs", {mem_addr1, mem_addr0}, 0);
    check("mid_rst_bound", {bound_valid, bound_last, bound_data}, 0);
    reset = 0;
    run_sweep(0, 0, 0, 0, 0, 0, 1);

    run_sweep(2, 1, 2, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
